vdp18_vram_capture: RTL and testbench
=====================================

VDP18_VRAM_CAPTURE -- requirements
Module: vdp18_vram_capture

Interface
REQ-001 Parameter: READ_LATENCY, 2, clk_en_i ticks from the address slot to valid vram_d_i; legal range 1..3.
REQ-002 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 reset_i  in  1  reset; synchronous, active-high.
REQ-004 clk_en_i  in  1  access-slot enable; the pipeline advances only when high.
REQ-005 access_type_i  in  access_t  access type of the slot whose address is presented this cycle.
REQ-006 cpu_wr_i  in  1  for an AC_CPU slot: 1 = write, 0 = read.
REQ-007 cpu_rd_req_i  in  1  CPU read request; level, held until cpu_rd_ack_o.
REQ-008 vram_d_i  in  [0:7]  VRAM read data.
REQ-009 pat_name_o, pat_col_o, pat_gen_o  out  [0:7] each  captured pattern name, color and generator bytes.
REQ-010 spr_y_o, spr_x_o, spr_name_o, spr_col_o  out  [0:7] each  captured sprite attribute bytes.
REQ-011 spr_pat_hi_o, spr_pat_lo_o  out  [0:7] each  captured sprite pattern upper and lower bytes.
REQ-012 cap_stb_o  out  [0:10]  one-cycle capture strobe per field: bits 0..10 = PNT, PCT, PGT, STST, SATY, SATX, SATN, SATC, SPTH, SPTL, CPU.
REQ-013 spr_term_o  out  1  sprite list terminator seen (Y byte = 0xD0).
REQ-014 cpu_rd_data_o  out  [0:7]  CPU read-ahead data.
REQ-015 cpu_rd_ack_o  out  1  one-cycle CPU read acknowledge.

Function
REQ-016 The block SHALL hold a READ_LATENCY-deep shift pipeline of {access type, read tag}, loaded from access_type_i when clk_en_i=1 and frozen when clk_en_i=0.
REQ-017 Read tag = 1 only when access_type_i=AC_CPU and cpu_wr_i=0 and cpu_rd_req_i=1 and no CPU read is in flight; otherwise 0.
REQ-018 A CPU read SHALL be in flight from the cycle its tag enters the pipeline until the cycle its ack is issued; at most one CPU read may be in flight.
REQ-019 When clk_en_i=1, the pipeline output entry SHALL be decoded against vram_d_i in that cycle, and the result SHALL be registered on that edge.
REQ-020 PNT/PCT/PGT/SATX/SATN/SATC/SPTH/SPTL output entries: the matching data register SHALL load vram_d_i, and the matching cap_stb_o bit SHALL be 1 for exactly the next cycle.
REQ-021 STST and SATY output entries: spr_y_o SHALL load vram_d_i, and strobe bit 3 or bit 4 SHALL be set respectively.
REQ-022 STST/SATY with vram_d_i=0xD0: spr_term_o SHALL set and stay set until a STST capture with vram_d_i!=0xD0 or reset.
REQ-023 AC_CPU output entry with read tag=1: cpu_rd_data_o SHALL load vram_d_i, and cpu_rd_ack_o and cap_stb_o[10] SHALL be 1 for exactly the next cycle.
REQ-024 AC_CPU output entries with tag=0 (writes) and AC_NONE entries SHALL change no register and raise no strobe.
REQ-025 Strobes and ack SHALL be 0 in every cycle with no capture on the previous edge, including every cycle after clk_en_i=0.
REQ-026 Latency: data presented READ_LATENCY enabled ticks after its slot appears on registered outputs one clk_i cycle after that tick.
REQ-027 A new cpu_rd_req_i in the ack cycle SHALL become taggable only at the next AC_CPU read slot after ack; the same request SHALL never be acked twice if the requester drops it on ack.
REQ-028 cpu_rd_req_i dropped while a read is in flight SHALL not cancel it; ack and data SHALL still be issued.
REQ-029 The pipeline SHALL contain no combinational path from vram_d_i to any output.

Reset
REQ-030 While reset_i=1 at a clock edge, all pipeline entries SHALL become AC_NONE with tag 0, and the in-flight flag SHALL clear.
REQ-031 While reset_i=1 at a clock edge, all data outputs SHALL become 0x00, all strobes SHALL become 0, spr_term_o SHALL become 0, and cpu_rd_ack_o SHALL become 0.
REQ-032 A reset asserted while a CPU read is in flight SHALL drop that read without an ack; after reset, the still-held request SHALL be retagged at the next AC_CPU read slot.

Verification
REQ-033 READ_LATENCY=2, clk_en_i held 1, AC_PNT then AC_NONE, vram_d_i=0x5A on the second tick -> pat_name_o=0x5A and cap_stb_o[0]=1 for one cycle; no other strobe.
REQ-034 cpu_rd_req_i=1, AC_CPU with cpu_wr_i=0, data 0x3C after latency -> cpu_rd_data_o=0x3C and cpu_rd_ack_o pulses once; req held for one extra cycle -> no second ack without a new AC_CPU slot.
REQ-035 AC_CPU with cpu_wr_i=1 while cpu_rd_req_i=1 -> no ack and no capture; the following AC_CPU read slot is acked.
REQ-036 AC_SATY with data 0xD0 -> spr_term_o=1; a later AC_STST with data 0x10 -> spr_term_o=0 and spr_y_o=0x10.
REQ-037 clk_en_i toggling 1,0,0,1 between the slot and the capture -> capture occurs only after READ_LATENCY enabled ticks, with values unchanged by disabled cycles.
REQ-038 reset_i pulsed one cycle with a CPU read in flight -> no ack, all outputs 0x00; request retagged and acked at the next AC_CPU read slot.

Source files
------------

// File: rtl/vdp18_vram_capture.sv
// ---------------------------------------------------------------------------
// vdp18_vram_capture
//   Captures VRAM read data returned READ_LATENCY enabled slots after the
//   address slot was issued, and steers each byte into the register that
//   belongs to the access type of that slot (pattern name/color/generator,
//   sprite attributes, sprite pattern, CPU read-ahead).
//
// Ports
//   clk_i          single clock, rising-edge
//   reset_i        synchronous, active-high reset
//   clk_en_i       access-slot enable; the slot pipeline only moves when high
//   access_type_i  access type of the slot whose address is presented now
//   cpu_wr_i       for an AC_CPU slot: 1 = write, 0 = read
//   cpu_rd_req_i   CPU read request (level)
//   vram_d_i       VRAM read data
//   pat_*_o        captured pattern name / color / generator bytes
//   spr_*_o        captured sprite attribute and pattern bytes
//   cap_stb_o      one-cycle capture strobe per field, bits 0..10 =
//                  PNT,PCT,PGT,STST,SATY,SATX,SATN,SATC,SPTH,SPTL,CPU
//   spr_term_o     sprite list terminator (Y = 0xD0) seen
//   cpu_rd_data_o  CPU read-ahead data
//   cpu_rd_ack_o   one-cycle CPU read acknowledge
//
// CPU read handshake: the requester raises cpu_rd_req_i and holds it until it
// sees cpu_rd_ack_o for one cycle; cpu_rd_data_o is valid from that cycle on.
// The request is consumed when an AC_CPU read slot tags it. While a read is in
// flight, and during its ack cycle, no further read is tagged, so a request
// dropped on ack is never acknowledged twice. Dropping the request while in
// flight does not cancel the read.
// ---------------------------------------------------------------------------
package vdp18_vram_capture_pkg;
  typedef enum logic [3:0] {
    AC_NONE = 4'd0,
    AC_PNT  = 4'd1,
    AC_PCT  = 4'd2,
    AC_PGT  = 4'd3,
    AC_STST = 4'd4,
    AC_SATY = 4'd5,
    AC_SATX = 4'd6,
    AC_SATN = 4'd7,
    AC_SATC = 4'd8,
    AC_SPTH = 4'd9,
    AC_SPTL = 4'd10,
    AC_CPU  = 4'd11
  } access_t;
endpackage

module vdp18_vram_capture
  import vdp18_vram_capture_pkg::*;
#(
  parameter int READ_LATENCY = 2  // legal range 1..3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  input  access_t     access_type_i,
  input  logic        cpu_wr_i,
  input  logic        cpu_rd_req_i,
  input  logic [0:7]  vram_d_i,
  output logic [0:7]  pat_name_o,
  output logic [0:7]  pat_col_o,
  output logic [0:7]  pat_gen_o,
  output logic [0:7]  spr_y_o,
  output logic [0:7]  spr_x_o,
  output logic [0:7]  spr_name_o,
  output logic [0:7]  spr_col_o,
  output logic [0:7]  spr_pat_hi_o,
  output logic [0:7]  spr_pat_lo_o,
  output logic [0:10] cap_stb_o,
  output logic        spr_term_o,
  output logic [0:7]  cpu_rd_data_o,
  output logic        cpu_rd_ack_o
);

  // Slot pipeline: entry 0 is loaded from the current slot, entry
  // READ_LATENCY-1 is the one whose data is on vram_d_i this tick.
  access_t r_pipe_type [READ_LATENCY];
  logic    r_pipe_tag  [READ_LATENCY];
  logic    r_in_flight;

  logic    w_tag;
  access_t w_out_type;
  logic    w_out_tag;
  logic    w_term_byte;

  // Blocking on the ack cycle too keeps a request that is dropped on ack from
  // being tagged a second time.
  assign w_tag = (access_type_i == AC_CPU) && !cpu_wr_i && cpu_rd_req_i &&
                 !r_in_flight && !cpu_rd_ack_o;

  assign w_out_type  = r_pipe_type[READ_LATENCY-1];
  assign w_out_tag   = r_pipe_tag[READ_LATENCY-1];
  assign w_term_byte = (vram_d_i == 8'hD0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_type[i] <= AC_NONE;
        r_pipe_tag[i]  <= 1'b0;
      end
      r_in_flight   <= 1'b0;
      pat_name_o    <= '0;
      pat_col_o     <= '0;
      pat_gen_o     <= '0;
      spr_y_o       <= '0;
      spr_x_o       <= '0;
      spr_name_o    <= '0;
      spr_col_o     <= '0;
      spr_pat_hi_o  <= '0;
      spr_pat_lo_o  <= '0;
      cap_stb_o     <= '0;
      spr_term_o    <= 1'b0;
      cpu_rd_data_o <= '0;
      cpu_rd_ack_o  <= 1'b0;
    end else begin
      // Strobes and ack are single-cycle: cleared unless a capture fires now.
      cap_stb_o    <= '0;
      cpu_rd_ack_o <= 1'b0;
      if (clk_en_i) begin
        r_pipe_type[0] <= access_type_i;
        r_pipe_tag[0]  <= w_tag;
        for (int i = 1; i < READ_LATENCY; i++) begin
          r_pipe_type[i] <= r_pipe_type[i-1];
          r_pipe_tag[i]  <= r_pipe_tag[i-1];
        end
        if (w_tag) r_in_flight <= 1'b1;

        case (w_out_type)
          AC_PNT:  begin pat_name_o   <= vram_d_i; cap_stb_o[0] <= 1'b1; end
          AC_PCT:  begin pat_col_o    <= vram_d_i; cap_stb_o[1] <= 1'b1; end
          AC_PGT:  begin pat_gen_o    <= vram_d_i; cap_stb_o[2] <= 1'b1; end
          AC_STST: begin
            spr_y_o      <= vram_d_i;
            cap_stb_o[3] <= 1'b1;
            // A status-scan Y byte both sets and clears the terminator.
            spr_term_o   <= w_term_byte;
          end
          AC_SATY: begin
            spr_y_o      <= vram_d_i;
            cap_stb_o[4] <= 1'b1;
            if (w_term_byte) spr_term_o <= 1'b1;
          end
          AC_SATX: begin spr_x_o      <= vram_d_i; cap_stb_o[5] <= 1'b1; end
          AC_SATN: begin spr_name_o   <= vram_d_i; cap_stb_o[6] <= 1'b1; end
          AC_SATC: begin spr_col_o    <= vram_d_i; cap_stb_o[7] <= 1'b1; end
          AC_SPTH: begin spr_pat_hi_o <= vram_d_i; cap_stb_o[8] <= 1'b1; end
          AC_SPTL: begin spr_pat_lo_o <= vram_d_i; cap_stb_o[9] <= 1'b1; end
          AC_CPU: begin
            // Untagged CPU entries are writes or unrequested reads: ignored.
            if (w_out_tag) begin
              cpu_rd_data_o <= vram_d_i;
              cpu_rd_ack_o  <= 1'b1;
              cap_stb_o[10] <= 1'b1;
              r_in_flight   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdp18_vram_capture.sv
// ---------------------------------------------------------------------------
// tb_vdp18_vram_capture
//   Directed bench for vdp18_vram_capture with READ_LATENCY = 2. Inputs are
//   driven and outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_vdp18_vram_capture;
  import vdp18_vram_capture_pkg::*;

  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        clk_en_i;
  access_t     access_type_i;
  logic        cpu_wr_i;
  logic        cpu_rd_req_i;
  logic [0:7]  vram_d_i;
  logic [0:7]  pat_name_o, pat_col_o, pat_gen_o;
  logic [0:7]  spr_y_o, spr_x_o, spr_name_o, spr_col_o;
  logic [0:7]  spr_pat_hi_o, spr_pat_lo_o;
  logic [0:10] cap_stb_o;
  logic        spr_term_o;
  logic [0:7]  cpu_rd_data_o;
  logic        cpu_rd_ack_o;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  vdp18_vram_capture #(.READ_LATENCY(LAT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .access_type_i(access_type_i), .cpu_wr_i(cpu_wr_i),
    .cpu_rd_req_i(cpu_rd_req_i), .vram_d_i(vram_d_i),
    .pat_name_o(pat_name_o), .pat_col_o(pat_col_o), .pat_gen_o(pat_gen_o),
    .spr_y_o(spr_y_o), .spr_x_o(spr_x_o), .spr_name_o(spr_name_o),
    .spr_col_o(spr_col_o), .spr_pat_hi_o(spr_pat_hi_o),
    .spr_pat_lo_o(spr_pat_lo_o), .cap_stb_o(cap_stb_o),
    .spr_term_o(spr_term_o), .cpu_rd_data_o(cpu_rd_data_o),
    .cpu_rd_ack_o(cpu_rd_ack_o)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:10] stb(input int b);
    logic [0:10] s;
    s = '0;
    if (b >= 0) s[b] = 1'b1;
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input access_t t, input logic wr, input logic [7:0] d,
                     input logic en);
    access_type_i = t;
    cpu_wr_i      = wr;
    vram_d_i      = d;
    clk_en_i      = en;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_pat_name"}, {24'd0, pat_name_o}, 32'h00);
    check({pfx, "_spr_y"},    {24'd0, spr_y_o},    32'h00);
    check({pfx, "_cpu_data"}, {24'd0, cpu_rd_data_o}, 32'h00);
    check({pfx, "_stb"},      {21'd0, cap_stb_o},  32'h0);
    check({pfx, "_term"},     {31'd0, spr_term_o}, 32'h0);
    check({pfx, "_ack"},      {31'd0, cpu_rd_ack_o}, 32'h0);
  endtask

  // Burst table: back-to-back slots, one capture per tick.
  access_t    burst_t [6];
  logic [7:0] burst_d [6];
  int         burst_b [6];

  function automatic logic [7:0] field_of(input access_t t);
    case (t)
      AC_PCT:  return pat_col_o;
      AC_SATX: return spr_x_o;
      AC_SATN: return spr_name_o;
      AC_SATC: return spr_col_o;
      AC_SPTH: return spr_pat_hi_o;
      AC_SPTL: return spr_pat_lo_o;
      default: return 8'hxx;
    endcase
  endfunction

  initial begin
    burst_t = '{AC_PCT, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL};
    burst_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    burst_b = '{1, 5, 6, 7, 8, 9};

    reset_i = 1'b1; cpu_rd_req_i = 1'b0;
    cyc(AC_NONE, 1'b0, 8'hFF, 1'b1);
    cyc(AC_NONE, 1'b0, 8'hFF, 1'b1);
    reset_i = 1'b0;
    check_cleared("reset");

    // PNT slot, data two ticks later
    cyc(AC_PNT,  1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    check("pnt_early_stb", {21'd0, cap_stb_o}, 32'h0);
    cyc(AC_NONE, 1'b0, 8'h5A, 1'b1);
    check("pnt_data", {24'd0, pat_name_o}, 32'h5A);
    check("pnt_stb",  {21'd0, cap_stb_o}, {21'd0, stb(0)});
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    check("pnt_stb_clr", {21'd0, cap_stb_o}, 32'h0);
    check("pnt_hold",    {24'd0, pat_name_o}, 32'h5A);

    // Burst over the remaining plain fields
    for (int i = 0; i < 6 + LAT; i++) begin
      cyc(i < 6 ? burst_t[i] : AC_NONE, 1'b0,
          i >= LAT ? burst_d[i-LAT] : 8'h00, 1'b1);
      if (i >= LAT) begin
        check($sformatf("burst_data%0d", i - LAT),
              {24'd0, field_of(burst_t[i-LAT])}, {24'd0, burst_d[i-LAT]});
        check($sformatf("burst_stb%0d", i - LAT),
              {21'd0, cap_stb_o}, {21'd0, stb(burst_b[i-LAT])});
      end
    end

    // CPU read, request held through the ack cycle
    cpu_rd_req_i = 1'b1;
    cyc(AC_CPU,  1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h3C, 1'b1);
    check("cpu_data", {24'd0, cpu_rd_data_o}, 32'h3C);
    check("cpu_ack",  {31'd0, cpu_rd_ack_o}, 32'h1);
    check("cpu_stb",  {21'd0, cap_stb_o}, {21'd0, stb(10)});
    // AC_CPU read slot during the ack cycle must not retag the held request
    cyc(AC_CPU,  1'b0, 8'h00, 1'b1);
    check("cpu_ack_once", {31'd0, cpu_rd_ack_o}, 32'h0);
    cpu_rd_req_i = 1'b0;
    cyc(AC_NONE, 1'b0, 8'h77, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h77, 1'b1);
    check("cpu_no_second_ack", {31'd0, cpu_rd_ack_o}, 32'h0);
    check("cpu_data_kept", {24'd0, cpu_rd_data_o}, 32'h3C);

    // CPU write slot ignored, following read acked; request dropped in flight
    cpu_rd_req_i = 1'b1;
    cyc(AC_CPU,  1'b1, 8'h00, 1'b1);
    cyc(AC_CPU,  1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'hEE, 1'b1);
    check("wr_no_ack",  {31'd0, cpu_rd_ack_o}, 32'h0);
    check("wr_no_stb",  {21'd0, cap_stb_o}, 32'h0);
    check("wr_no_data", {24'd0, cpu_rd_data_o}, 32'h3C);
    cpu_rd_req_i = 1'b0;
    cyc(AC_NONE, 1'b0, 8'h91, 1'b1);
    check("rd_after_wr_ack",  {31'd0, cpu_rd_ack_o}, 32'h1);
    check("rd_after_wr_data", {24'd0, cpu_rd_data_o}, 32'h91);

    // Sprite terminator set by SATY, cleared by STST
    cyc(AC_SATY, 1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'hD0, 1'b1);
    check("saty_term", {31'd0, spr_term_o}, 32'h1);
    check("saty_y",    {24'd0, spr_y_o}, 32'hD0);
    check("saty_stb",  {21'd0, cap_stb_o}, {21'd0, stb(4)});
    cyc(AC_STST, 1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    check("term_sticky", {31'd0, spr_term_o}, 32'h1);
    cyc(AC_NONE, 1'b0, 8'h10, 1'b1);
    check("stst_term", {31'd0, spr_term_o}, 32'h0);
    check("stst_y",    {24'd0, spr_y_o}, 32'h10);
    check("stst_stb",  {21'd0, cap_stb_o}, {21'd0, stb(3)});

    // Enable gaps between slot and capture: 1,0,0,1 then capture
    cyc(AC_PGT,  1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'hAA, 1'b0);
    cyc(AC_NONE, 1'b0, 8'hAA, 1'b0);
    check("gap_stb", {21'd0, cap_stb_o}, 32'h0);
    check("gap_pgt", {24'd0, pat_gen_o}, 32'h00);
    cyc(AC_NONE, 1'b0, 8'hBB, 1'b1);
    check("gap_pgt_wait", {24'd0, pat_gen_o}, 32'h00);
    cyc(AC_NONE, 1'b0, 8'h3D, 1'b1);
    check("gap_pgt_data", {24'd0, pat_gen_o}, 32'h3D);
    check("gap_pgt_stb",  {21'd0, cap_stb_o}, {21'd0, stb(2)});
    cyc(AC_NONE, 1'b0, 8'h00, 1'b0);
    check("dis_stb_clr", {21'd0, cap_stb_o}, 32'h0);

    // Reset with a CPU read in flight
    cpu_rd_req_i = 1'b1;
    cyc(AC_CPU,  1'b0, 8'h00, 1'b1);
    reset_i = 1'b1;
    cyc(AC_NONE, 1'b0, 8'h55, 1'b1);
    reset_i = 1'b0;
    check_cleared("rst_fl");
    cyc(AC_NONE, 1'b0, 8'h55, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h55, 1'b1);
    check("rst_dropped_ack", {31'd0, cpu_rd_ack_o}, 32'h0);
    check("rst_dropped_data", {24'd0, cpu_rd_data_o}, 32'h00);
    cyc(AC_CPU,  1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    cyc(AC_NONE, 1'b0, 8'h66, 1'b1);
    check("retag_ack",  {31'd0, cpu_rd_ack_o}, 32'h1);
    check("retag_data", {24'd0, cpu_rd_data_o}, 32'h66);
    cpu_rd_req_i = 1'b0;
    cyc(AC_NONE, 1'b0, 8'h00, 1'b1);
    check("retag_ack_clr", {31'd0, cpu_rd_ack_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
